// File: rtl/ldpc_cnu_minsum_if.sv
// Stream bundle for the min-sum check-node unit: V2C input beats with row
// configuration on one side, C2V output beats on the other.
interface ldpc_cnu_minsum_if #(
    parameter int MSG_WIDTH = 6,
    parameter int DEG_MAX   = 32,
    parameter int IDX_WIDTH = $clog2(DEG_MAX)
);
    logic [1:0]                  cfg_mode;
    logic [7:0]                  cfg_alpha;
    logic [MSG_WIDTH-2:0]        cfg_beta;

    logic                        in_valid;
    logic                        in_ready;
    logic signed [MSG_WIDTH-1:0] in_data;
    logic                        in_last;

    logic                        out_valid;
    logic                        out_ready;
    logic signed [MSG_WIDTH-1:0] out_data;
    logic                        out_last;
    logic [IDX_WIDTH-1:0]        out_idx;

    logic                        err_overflow;

    modport master (
        output cfg_mode, cfg_alpha, cfg_beta,
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_last, out_idx, err_overflow
    );

    modport slave (
        input  cfg_mode, cfg_alpha, cfg_beta,
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_last, out_idx, err_overflow
    );
endinterface

// File: rtl/ldpc_cnu_minsum.sv
// Serial min-sum check-node unit: collects one V2C message per beat into one of
// two ping-pong row slots, then emits that row's C2V messages one per beat.
module ldpc_cnu_minsum #(
    parameter int MSG_WIDTH = 6,
    parameter int DEG_MAX   = 32,
    parameter int IDX_WIDTH = $clog2(DEG_MAX)
) (
    input  logic             clk,
    input  logic             rst,
    ldpc_cnu_minsum_if.slave bus
);
    localparam int MW = MSG_WIDTH - 1;
    localparam int PW = MW + 8;
    localparam logic [MW-1:0]        MAG_MAX = '1;
    localparam logic [IDX_WIDTH-1:0] CNT_MAX = IDX_WIDTH'(DEG_MAX - 1);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_FILL  = 2'd1,
        S_FULL  = 2'd2,
        S_EMIT  = 2'd3
    } slot_state_t;

    typedef struct packed {
        slot_state_t          state;
        logic [MW-1:0]        min1;
        logic [MW-1:0]        min2;
        logic [IDX_WIDTH-1:0] idx1;
        logic [IDX_WIDTH-1:0] last_idx;
        logic                 sprod;
        logic [DEG_MAX-1:0]   signs;
        logic [1:0]           mode;
        logic [7:0]           alpha;
        logic [MW-1:0]        beta;
    } slot_t;

    slot_t                slot_q [2];
    slot_t                slot_d [2];
    logic                 wr_sel_q, wr_sel_d;
    logic                 rd_sel_q, rd_sel_d;
    logic [IDX_WIDTH-1:0] cnt_q, cnt_d;
    logic                 in_ready_q, in_ready_d;
    logic                 ovf_q, ovf_d;
    logic                 out_valid_q, out_valid_d;
    logic [MSG_WIDTH-1:0] out_data_q, out_data_d;
    logic                 out_last_q, out_last_d;
    logic [IDX_WIDTH-1:0] out_idx_q, out_idx_d;

    logic                 accept;
    logic                 sign_in;
    logic                 row_end;
    logic                 advance;
    logic                 load;
    logic                 neg;
    logic [MW-1:0]        mag;
    logic [MW-1:0]        m;
    logic [MW-1:0]        m_scaled;
    logic [IDX_WIDTH-1:0] j;
    slot_t                cur;

    // The most negative message has no positive twin, so it saturates.
    always_comb begin
        sign_in = bus.in_data[MSG_WIDTH-1];
        if (!sign_in) begin
            mag = bus.in_data[MW-1:0];
        end else if (bus.in_data[MW-1:0] == '0) begin
            mag = MAG_MAX;
        end else begin
            mag = MW'(-bus.in_data);
        end
    end

    always_comb begin
        slot_d      = slot_q;
        wr_sel_d    = wr_sel_q;
        rd_sel_d    = rd_sel_q;
        cnt_d       = cnt_q;
        ovf_d       = 1'b0;
        row_end     = 1'b0;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        out_idx_d   = out_idx_q;
        accept      = bus.in_valid && in_ready_q;

        cur = slot_q[wr_sel_q];
        if (cur.state == S_EMPTY) begin
            cur.min1  = MAG_MAX;
            cur.min2  = MAG_MAX;
            cur.idx1  = '0;
            cur.sprod = 1'b0;
            cur.signs = '0;
            cur.mode  = bus.cfg_mode;
            cur.alpha = bus.cfg_alpha;
            cur.beta  = bus.cfg_beta;
        end

        if (accept) begin
            cur.signs[cnt_q] = sign_in;
            cur.sprod        = cur.sprod ^ sign_in;
            if (mag < cur.min1) begin
                cur.min2 = cur.min1;
                cur.min1 = mag;
                cur.idx1 = cnt_q;
            end else if (mag < cur.min2) begin
                cur.min2 = mag;
            end
            row_end = bus.in_last || (cnt_q == CNT_MAX);
            ovf_d   = !bus.in_last && (cnt_q == CNT_MAX);
            if (row_end) begin
                cur.state    = S_FULL;
                cur.last_idx = cnt_q;
                cnt_d        = '0;
                wr_sel_d     = ~wr_sel_q;
            end else begin
                cur.state = S_FILL;
                cnt_d     = cnt_q + 1'b1;
            end
            slot_d[wr_sel_q] = cur;
        end

        // Emitter looks at post-collection slot state so a row finishing this
        // cycle can start emitting on the very next one.
        advance = !out_valid_q || bus.out_ready;
        load    = 1'b0;
        j       = out_idx_q;
        if (advance) begin
            if (out_valid_q && !out_last_q) begin
                load = 1'b1;
                j    = out_idx_q + 1'b1;
            end else begin
                if (out_valid_q) begin
                    slot_d[rd_sel_q].state = S_EMPTY;
                    rd_sel_d               = ~rd_sel_q;
                end
                if (slot_d[rd_sel_d].state == S_FULL) begin
                    slot_d[rd_sel_d].state = S_EMIT;
                    load                   = 1'b1;
                    j                      = '0;
                end
            end
            out_valid_d = load;
        end

        m = (j == slot_d[rd_sel_d].idx1) ? slot_d[rd_sel_d].min2 : slot_d[rd_sel_d].min1;
        case (slot_d[rd_sel_d].mode)
            2'b01:   m_scaled = MW'((PW'(m) * PW'(slot_d[rd_sel_d].alpha)) >> 8);
            2'b10:   m_scaled = (m > slot_d[rd_sel_d].beta) ? m - slot_d[rd_sel_d].beta : '0;
            default: m_scaled = m;
        endcase
        neg = slot_d[rd_sel_d].sprod ^ slot_d[rd_sel_d].signs[j];

        if (load) begin
            out_data_d = neg ? -{1'b0, m_scaled} : {1'b0, m_scaled};
            out_last_d = (j == slot_d[rd_sel_d].last_idx);
            out_idx_d  = j;
        end

        in_ready_d = (slot_d[wr_sel_d].state == S_EMPTY) || (slot_d[wr_sel_d].state == S_FILL);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                slot_q[i] <= '0;
            end
            wr_sel_q    <= 1'b0;
            rd_sel_q    <= 1'b0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_idx_q   <= '0;
        end else begin
            slot_q      <= slot_d;
            wr_sel_q    <= wr_sel_d;
            rd_sel_q    <= rd_sel_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            out_idx_q   <= out_idx_d;
        end
    end

    assign bus.in_ready     = in_ready_q;
    assign bus.out_valid    = out_valid_q;
    assign bus.out_data     = out_data_q;
    assign bus.out_last     = out_last_q;
    assign bus.out_idx      = out_idx_q;
    assign bus.err_overflow = ovf_q;
endmodule

// File: tb/tb_ldpc_cnu_minsum.sv
// Self-checking bench for ldpc_cnu_minsum: directed and random rows are
// checked against a row-level min-sum reference model.
`timescale 1ns/1ps
module tb_ldpc_cnu_minsum;
    localparam int W      = 6;
    localparam int DMAX   = 32;
    localparam int IW     = 5;
    localparam int MAGMAX = (1 << (W - 1)) - 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ldpc_cnu_minsum_if #(.MSG_WIDTH(W), .DEG_MAX(DMAX), .IDX_WIDTH(IW)) bus ();

    ldpc_cnu_minsum #(.MSG_WIDTH(W), .DEG_MAX(DMAX), .IDX_WIDTH(IW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic signed [W-1:0] data;
        logic [IW-1:0]       idx;
        logic                last;
    } beat_t;

    beat_t               exp_q[$];
    int                  checks     = 0;
    int                  errors     = 0;
    int                  ovf_count  = 0;
    int                  row_vals[64];
    int                  buf_vals[DMAX];
    int                  buf_n      = 0;
    int                  buf_mode   = 0;
    int                  buf_alpha  = 0;
    int                  buf_beta   = 0;
    bit                  rand_ready = 1'b0;
    logic signed [W-1:0] hold_data;
    logic [IW-1:0]       hold_idx;
    logic                hold_last;
    bit                  stalled    = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int mag_of(input int v);
        int a;
        a = (v < 0) ? -v : v;
        return (a > MAGMAX) ? MAGMAX : a;
    endfunction

    // Each output is the min-sum of all OTHER inputs of the row.
    task automatic model_row();
        for (int jj = 0; jj < buf_n; jj++) begin
            int    mm;
            int    ng;
            beat_t b;
            mm = MAGMAX;
            ng = 0;
            for (int k = 0; k < buf_n; k++) begin
                if (k != jj) begin
                    if (mag_of(buf_vals[k]) < mm) mm = mag_of(buf_vals[k]);
                    if (buf_vals[k] < 0) ng ^= 1;
                end
            end
            case (buf_mode)
                1:       mm = (mm * buf_alpha) / 256;
                2:       mm = (mm > buf_beta) ? mm - buf_beta : 0;
                default: mm = mm;
            endcase
            if (ng != 0) mm = -mm;
            b.data = mm[W-1:0];
            b.idx  = jj[IW-1:0];
            b.last = (jj == buf_n - 1);
            exp_q.push_back(b);
        end
        buf_n = 0;
    endtask

    task automatic model_accept(input int v, input logic last);
        if (buf_n == 0) begin
            buf_mode  = int'(bus.cfg_mode);
            buf_alpha = int'(bus.cfg_alpha);
            buf_beta  = int'(bus.cfg_beta);
        end
        buf_vals[buf_n] = v;
        buf_n++;
        if (last || buf_n == DMAX) model_row();
    endtask

    task automatic send_beat(input int v, input logic last);
        int guard;
        guard        = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = v[W-1:0];
        bus.in_last  = last;
        while (!bus.in_ready && guard < 500) begin
            if (rand_ready) bus.out_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
            guard++;
        end
        if (!bus.in_ready) begin
            check("in_ready_wait", bus.in_ready, 1);
            bus.in_valid = 1'b0;
        end else begin
            @(posedge clk); #1;
            model_accept(v, last);
            bus.in_valid = 1'b0;
            if (rand_ready) bus.out_ready = ($urandom_range(0, 3) != 0);
        end
    endtask

    // Config is scrambled after the first beat; the unit must ignore that.
    task automatic send_row(input int n, input int mode, input int alpha, input int beta);
        bus.cfg_mode  = mode[1:0];
        bus.cfg_alpha = alpha[7:0];
        bus.cfg_beta  = beta[W-2:0];
        for (int i = 0; i < n; i++) begin
            send_beat(row_vals[i], (i == n - 1));
            if (i == 0) begin
                bus.cfg_mode  = 2'($urandom_range(0, 3));
                bus.cfg_alpha = 8'($urandom_range(0, 255));
                bus.cfg_beta  = (W-1)'($urandom_range(0, MAGMAX));
            end
        end
    endtask

    task automatic fill_random(input int n);
        for (int i = 0; i < n; i++) begin
            int r;
            r = int'($urandom_range(0, (1 << W) - 1));
            row_vals[i] = (r >= (1 << (W - 1))) ? r - (1 << W) : r;
        end
    endtask

    task automatic wait_drain();
        int g;
        g = 0;
        while ((exp_q.size() != 0 || bus.out_valid) && g < 400) begin
            @(posedge clk); #1;
            g++;
        end
        if (g >= 400) check("drain_left", exp_q.size(), 0);
    endtask

    // Output monitor: scoreboard on every handshake, stability under stall.
    always @(negedge clk) begin
        beat_t b;
        if (rst) begin
            stalled = 1'b0;
        end else begin
            if (bus.err_overflow) ovf_count++;
            if (stalled) begin
                check("stall_data", bus.out_data, hold_data);
                check("stall_idx", bus.out_idx, hold_idx);
                check("stall_last", bus.out_last, hold_last);
            end
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out", bus.out_valid, 0);
                end else begin
                    b = exp_q.pop_front();
                    check("out_data", bus.out_data, b.data);
                    check("out_idx", bus.out_idx, b.idx);
                    check("out_last", bus.out_last, b.last);
                end
            end
            stalled   = bus.out_valid && !bus.out_ready;
            hold_data = bus.out_data;
            hold_idx  = bus.out_idx;
            hold_last = bus.out_last;
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int g;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b1;
        bus.cfg_mode  = 2'b00;
        bus.cfg_alpha = 8'd0;
        bus.cfg_beta  = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_data", bus.out_data, 0);
        check("rst_out_last", bus.out_last, 0);
        check("rst_out_idx", bus.out_idx, 0);
        check("rst_err", bus.err_overflow, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("rel_in_ready", bus.in_ready, 1);

        $display("[TB] plain / normalized / offset rows");
        row_vals[0] = 5; row_vals[1] = -3; row_vals[2] = 7; row_vals[3] = -2;
        send_row(4, 0, 0, 0);
        check("latency_valid", bus.out_valid, 1);
        check("latency_idx", bus.out_idx, 0);
        wait_drain();
        send_row(4, 1, 192, 0);
        wait_drain();
        send_row(4, 2, 0, 2);
        wait_drain();
        send_row(4, 3, 0, 0);
        wait_drain();

        $display("[TB] saturation and degree-1 rows");
        row_vals[0] = -32; row_vals[1] = 4;
        send_row(2, 0, 0, 0);
        wait_drain();
        row_vals[0] = 9;
        send_row(1, 0, 0, 0);
        wait_drain();
        row_vals[0] = -20;
        send_row(1, 1, 100, 0);
        wait_drain();

        $display("[TB] ping-pong with backpressure");
        bus.out_ready = 1'b0;
        fill_random(4);
        send_row(4, 0, 0, 0);
        fill_random(4);
        send_row(4, 2, 0, 3);
        check("pp_in_ready_low", bus.in_ready, 0);
        bus.in_valid = 1'b1;
        bus.in_data  = 6'sd11;
        bus.in_last  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("pp_third_stalls", bus.in_ready, 0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check("pp_contiguous", bus.out_valid, 1);
            @(posedge clk); #1;
            check("pp_in_ready", bus.in_ready, (i >= 3) ? 1 : 0);
        end
        fill_random(4);
        send_row(4, 1, 205, 0);
        wait_drain();

        $display("[TB] overflow row");
        fill_random(33);
        send_row(33, 0, 0, 0);
        wait_drain();
        check("ovf_pulses", ovf_count, 1);

        $display("[TB] reset during emission");
        fill_random(6);
        send_row(6, 0, 0, 0);
        g = 0;
        while (!(bus.out_valid && bus.out_idx == 5'd2) && g < 50) begin
            @(posedge clk); #1;
            g++;
        end
        if (g >= 50) check("reach_idx2", bus.out_idx, 2);
        rst = 1'b1;
        @(posedge clk); #1;
        check("mid_rst_out_valid", bus.out_valid, 0);
        check("mid_rst_in_ready", bus.in_ready, 0);
        exp_q.delete();
        buf_n = 0;
        rst = 1'b0;
        @(posedge clk); #1;
        check("mid_rel_in_ready", bus.in_ready, 1);
        check("mid_rel_out_valid", bus.out_valid, 0);
        fill_random(5);
        send_row(5, 1, 160, 0);
        wait_drain();

        $display("[TB] random rows with random backpressure");
        rand_ready = 1'b1;
        for (int r = 0; r < 20; r++) begin
            int n;
            n = int'($urandom_range(1, 8));
            fill_random(n);
            send_row(n, int'($urandom_range(0, 3)), int'($urandom_range(0, 255)),
                     int'($urandom_range(0, MAGMAX)));
        end
        rand_ready    = 1'b0;
        bus.out_ready = 1'b1;
        wait_drain();
        check("final_queue_empty", exp_q.size(), 0);
        check("final_ovf_total", ovf_count, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
